// File: rtl/mod_exp_controller_if.sv
// Single valid/ready stream used for every operand, result and multiplier channel.
// The master drives tdata/tvalid. The slave drives tready.
interface mod_exp_controller_if #(
  parameter int unsigned SIZE = 64
) ();

  logic [SIZE-1:0] tdata;
  logic            tvalid;
  logic            tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/mod_exp_controller.sv
// Right-to-left square-and-multiply modular exponentiation that drives an external
// multiplication_modulo block. Optional macro MOD_EXP_SKIP_FINAL_SQUARE_EN drops the unused last square.
module mod_exp_controller #(
  parameter int unsigned SIZE = 64
) (
  input  logic clk,
  input  logic rst,
  mod_exp_controller_if.slave  input_base,
  mod_exp_controller_if.slave  input_exponent,
  mod_exp_controller_if.slave  input_modulus,
  mod_exp_controller_if.master output_result,
  mod_exp_controller_if.master mul_multiplier,
  mod_exp_controller_if.master mul_multiplicand,
  mod_exp_controller_if.master mul_modulus,
  mod_exp_controller_if.slave  mul_result
);

  localparam logic [SIZE-1:0] ZERO = '0;
  localparam logic [SIZE-1:0] ONE  = SIZE'(1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STEP,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] e;
    logic [SIZE-1:0] m;
    logic [SIZE-1:0] mr_data;
    logic [SIZE-1:0] md_data;
    logic [SIZE-1:0] mm_data;
    logic [SIZE-1:0] out_data;
    logic            have_base;
    logic            have_exp;
    logic            have_mod;
    logic            rdy_base;
    logic            rdy_exp;
    logic            rdy_mod;
    logic            op_mul;
    logic            mr_valid;
    logic            md_valid;
    logic            mm_valid;
    logic            res_ready;
    logic            out_valid;
  } regs_t;

  state_t state_q, state_d;
  regs_t  r_q, r_d;
  logic   launch;
  logic   finish;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  // Next-state and next-register logic. launch/finish share the ISSUE and DONE entry code.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    launch  = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (input_base.tvalid && r_q.rdy_base) begin
          r_d.b         = input_base.tdata;
          r_d.have_base = 1'b1;
        end
        if (input_exponent.tvalid && r_q.rdy_exp) begin
          r_d.e        = input_exponent.tdata;
          r_d.have_exp = 1'b1;
        end
        if (input_modulus.tvalid && r_q.rdy_mod) begin
          r_d.m        = input_modulus.tdata;
          r_d.have_mod = 1'b1;
        end
        r_d.rdy_base = !r_d.have_base;
        r_d.rdy_exp  = !r_d.have_exp;
        r_d.rdy_mod  = !r_d.have_mod;
        if (r_q.have_base && r_q.have_exp && r_q.have_mod) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        r_d.have_base = 1'b0;
        r_d.have_exp  = 1'b0;
        r_d.have_mod  = 1'b0;
        if (r_q.m <= ONE) begin
          r_d.acc = ZERO;
          finish  = 1'b1;
        end else if (r_q.e == ZERO) begin
          r_d.acc = ONE;
          finish  = 1'b1;
        end else begin
          r_d.acc = ONE;
          state_d = STEP;
        end
      end

      // A set bit 0 is cleared once its multiply is issued, so the next visit shifts and squares.
      STEP: begin
        if (r_q.e[0]) begin
          r_d.e[0]   = 1'b0;
          r_d.op_mul = 1'b1;
          launch     = 1'b1;
        end else begin
          r_d.e      = r_q.e >> 1;
          r_d.op_mul = 1'b0;
`ifdef MOD_EXP_SKIP_FINAL_SQUARE_EN
          if (r_d.e == ZERO) begin
            finish = 1'b1;
          end else begin
            launch = 1'b1;
          end
`else
          launch = 1'b1;
`endif
        end
      end

      ISSUE: begin
        if (r_q.mr_valid && mul_multiplier.tready) begin
          r_d.mr_valid = 1'b0;
        end
        if (r_q.md_valid && mul_multiplicand.tready) begin
          r_d.md_valid = 1'b0;
        end
        if (r_q.mm_valid && mul_modulus.tready) begin
          r_d.mm_valid = 1'b0;
        end
        if (!r_d.mr_valid && !r_d.md_valid && !r_d.mm_valid) begin
          r_d.res_ready = 1'b1;
          state_d       = WAIT;
        end
      end

      WAIT: begin
        if (mul_result.tvalid && r_q.res_ready) begin
          r_d.res_ready = 1'b0;
          if (r_q.op_mul) begin
            r_d.acc = mul_result.tdata;
            state_d = STEP;
          end else begin
            r_d.b = mul_result.tdata;
            if (r_q.e != ZERO) begin
              state_d = STEP;
            end else begin
              finish = 1'b1;
            end
          end
        end
      end

      DONE: begin
        if (output_result.tready && r_q.out_valid) begin
          r_d.out_valid = 1'b0;
          r_d.rdy_base  = 1'b1;
          r_d.rdy_exp   = 1'b1;
          r_d.rdy_mod   = 1'b1;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      r_d.mr_data  = r_d.op_mul ? r_q.acc : r_q.b;
      r_d.md_data  = r_q.b;
      r_d.mm_data  = r_q.m;
      r_d.mr_valid = 1'b1;
      r_d.md_valid = 1'b1;
      r_d.mm_valid = 1'b1;
      state_d      = ISSUE;
    end

    if (finish) begin
      r_d.out_data  = r_d.acc;
      r_d.out_valid = 1'b1;
      state_d       = DONE;
    end
  end

  assign input_base.tready     = r_q.rdy_base;
  assign input_exponent.tready = r_q.rdy_exp;
  assign input_modulus.tready  = r_q.rdy_mod;

  assign output_result.tdata  = r_q.out_data;
  assign output_result.tvalid = r_q.out_valid;

  assign mul_multiplier.tdata    = r_q.mr_data;
  assign mul_multiplier.tvalid   = r_q.mr_valid;
  assign mul_multiplicand.tdata  = r_q.md_data;
  assign mul_multiplicand.tvalid = r_q.md_valid;
  assign mul_modulus.tdata       = r_q.mm_data;
  assign mul_modulus.tvalid      = r_q.mm_valid;

  assign mul_result.tready = r_q.res_ready;

endmodule

// File: tb/tb_mod_exp_controller.sv
// Bench for mod_exp_controller: a multiplication_modulo responder with optional backpressure,
// plus an arithmetic reference for results and multiplier transaction counts.
module tb_mod_exp_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_exp_controller_if #(.SIZE(64)) in_base ();
  mod_exp_controller_if #(.SIZE(64)) in_exp ();
  mod_exp_controller_if #(.SIZE(64)) in_mod ();
  mod_exp_controller_if #(.SIZE(64)) out_res ();
  mod_exp_controller_if #(.SIZE(64)) mul_a ();
  mod_exp_controller_if #(.SIZE(64)) mul_b ();
  mod_exp_controller_if #(.SIZE(64)) mul_m ();
  mod_exp_controller_if #(.SIZE(64)) mul_r ();

  mod_exp_controller #(.SIZE(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .input_base       (in_base),
    .input_exponent   (in_exp),
    .input_modulus    (in_mod),
    .output_result    (out_res),
    .mul_multiplier   (mul_a),
    .mul_multiplicand (mul_b),
    .mul_modulus      (mul_m),
    .mul_result       (mul_r)
  );

  int checks = 0;
  int errors = 0;

`ifdef MOD_EXP_SKIP_FINAL_SQUARE_EN
  localparam bit SKIP_SQ = 1'b1;
`else
  localparam bit SKIP_SQ = 1'b0;
`endif

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
    logic [127:0] p;
    if (m == 64'd0) return 64'd0;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, m});
  endfunction

  function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [63:0] e,
                                          input logic [63:0] m);
    logic [63:0] r;
    logic [63:0] x;
    if (m <= 64'd1) return 64'd0;
    r = 64'd1;
    x = b % m;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = mulmod(r, x, m);
      x = mulmod(x, x, m);
    end
    return r;
  endfunction

  function automatic int ref_tx(input logic [63:0] e, input logic [63:0] m);
    int len;
    if (m <= 64'd1 || e == 64'd0) return 0;
    len = 0;
    for (int i = 0; i < 64; i++) if (e[i]) len = i + 1;
    return $countones(e) + len - (SKIP_SQ ? 1 : 0);
  endfunction

  // Multiplier responder
  bit          bp_en = 1'b0;
  int unsigned max_delay = 0;
  logic        cap_a, cap_b, cap_m, busy;
  logic [63:0] a_q, b_q, m_q, p_q;
  int unsigned dly;
  int          tx_count = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a.tready <= 1'b0;
      mul_b.tready <= 1'b0;
      mul_m.tready <= 1'b0;
      mul_r.tvalid <= 1'b0;
      mul_r.tdata  <= 64'd0;
      cap_a <= 1'b0;
      cap_b <= 1'b0;
      cap_m <= 1'b0;
      busy  <= 1'b0;
      dly   <= 0;
    end else begin
      if (mul_a.tvalid && mul_a.tready) begin cap_a <= 1'b1; a_q <= mul_a.tdata; end
      if (mul_b.tvalid && mul_b.tready) begin cap_b <= 1'b1; b_q <= mul_b.tdata; end
      if (mul_m.tvalid && mul_m.tready) begin cap_m <= 1'b1; m_q <= mul_m.tdata; end
      mul_a.tready <= !cap_a && !(mul_a.tvalid && mul_a.tready) && !busy &&
                      (!bp_en || $urandom_range(0, 1) == 1);
      mul_b.tready <= !cap_b && !(mul_b.tvalid && mul_b.tready) && !busy &&
                      (!bp_en || $urandom_range(0, 1) == 1);
      mul_m.tready <= !cap_m && !(mul_m.tvalid && mul_m.tready) && !busy &&
                      (!bp_en || $urandom_range(0, 1) == 1);
      if (!busy && cap_a && cap_b && cap_m) begin
        busy  <= 1'b1;
        cap_a <= 1'b0;
        cap_b <= 1'b0;
        cap_m <= 1'b0;
        p_q   <= mulmod(a_q, b_q, m_q);
        dly   <= bp_en ? $urandom_range(0, max_delay) : 0;
      end else if (busy && !mul_r.tvalid) begin
        if (dly == 0) begin
          mul_r.tvalid <= 1'b1;
          mul_r.tdata  <= p_q;
        end else begin
          dly <= dly - 1;
        end
      end else if (mul_r.tvalid && mul_r.tready) begin
        mul_r.tvalid <= 1'b0;
        busy         <= 1'b0;
        tx_count     <= tx_count + 1;
      end
    end
  end

  // Caller is at a negedge; returns just after the accepting posedge.
  task automatic send_one(input int idx, input logic [63:0] d, output bit ok);
    ok = 1'b0;
    case (idx)
      0: begin in_base.tdata = d; in_base.tvalid = 1'b1; end
      1: begin in_exp.tdata = d;  in_exp.tvalid = 1'b1;  end
      default: begin in_mod.tdata = d; in_mod.tvalid = 1'b1; end
    endcase
    for (int i = 0; i < 50; i++) begin
      bit hs;
      case (idx)
        0: hs = in_base.tready;
        1: hs = in_exp.tready;
        default: hs = in_mod.tready;
      endcase
      @(posedge clk); #1;
      if (hs) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    case (idx)
      0: in_base.tvalid = 1'b0;
      1: in_exp.tvalid = 1'b0;
      default: in_mod.tvalid = 1'b0;
    endcase
  endtask

  task automatic send_all(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m,
                          output bit ok);
    bit hb, he, hm;
    in_base.tdata = b; in_exp.tdata = e; in_mod.tdata = m;
    in_base.tvalid = 1'b1; in_exp.tvalid = 1'b1; in_mod.tvalid = 1'b1;
    for (int i = 0; i < 50 && (in_base.tvalid || in_exp.tvalid || in_mod.tvalid); i++) begin
      hb = in_base.tready; he = in_exp.tready; hm = in_mod.tready;
      @(posedge clk); #1;
      if (hb) in_base.tvalid = 1'b0;
      if (he) in_exp.tvalid = 1'b0;
      if (hm) in_mod.tvalid = 1'b0;
      @(negedge clk);
    end
    ok = !(in_base.tvalid || in_exp.tvalid || in_mod.tvalid);
    in_base.tvalid = 1'b0; in_exp.tvalid = 1'b0; in_mod.tvalid = 1'b0;
  endtask

  // Waits for the result, holds it for `hold` cycles, then accepts it. Ends on a negedge.
  task automatic collect(input int hold, input int tx0, output logic [63:0] res,
                         output int tx, output bit stable, output bit timed_out);
    timed_out = 1'b1;
    stable    = 1'b1;
    res       = 64'd0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (out_res.tvalid === 1'b1) begin timed_out = 1'b0; break; end
    end
    if (!timed_out) begin
      res = out_res.tdata;
      repeat (hold) begin
        @(negedge clk);
        if (out_res.tvalid !== 1'b1 || out_res.tdata !== res) stable = 1'b0;
      end
      out_res.tready = 1'b1;
      @(posedge clk); #1;
      out_res.tready = 1'b0;
      @(negedge clk);
    end
    tx = tx_count - tx0;
  endtask

  task automatic run_exp(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m,
                         input int hold, output logic [63:0] res, output int tx,
                         output bit stable, output bit timed_out);
    bit ok;
    int tx0;
    tx0 = tx_count;
    send_all(b, e, m, ok);
    if (!ok) begin
      timed_out = 1'b1; res = 64'd0; tx = 0; stable = 1'b0;
    end else begin
      collect(hold, tx0, res, tx, stable, timed_out);
    end
  endtask

  task automatic test_reset;
    logic [518:0] outs;
    outs = {in_base.tready, in_exp.tready, in_mod.tready, out_res.tvalid, out_res.tdata,
            mul_a.tvalid, mul_a.tdata, mul_b.tvalid, mul_b.tdata, mul_m.tvalid, mul_m.tdata,
            mul_r.tready, 64'd0};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", outs);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_base.tready, in_exp.tready, in_mod.tready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_readies got %b expected 111",
               {in_base.tready, in_exp.tready, in_mod.tready});
    end
    @(negedge clk);
  endtask

  task automatic test_single_bit;
    logic [63:0] res, b, e, m;
    int tx;
    bit st, to;
    b = 64'd143563561627; e = 64'd1; m = 64'd69814;
    run_exp(b, e, m, 0, res, tx, st, to);
    checks++;
    if (to || res !== ref_pow(b, e, m)) begin
      errors++;
      $display("FAIL single_bit_result got %0d expected %0d timeout %0d", res, ref_pow(b, e, m), to);
    end
    checks++;
    if (tx !== ref_tx(e, m)) begin
      errors++;
      $display("FAIL single_bit_tx got %0d expected %0d", tx, ref_tx(e, m));
    end
    checks++;
    if ({in_base.tready, in_exp.tready, in_mod.tready, out_res.tvalid} !== 4'b1110) begin
      errors++;
      $display("FAIL back_to_idle got %b expected 1110",
               {in_base.tready, in_exp.tready, in_mod.tready, out_res.tvalid});
    end
  endtask

  task automatic test_ordered;
    logic [63:0] res;
    int tx, tx0;
    bit ok, st, to;
    tx0 = tx_count;
    send_one(2, 64'd7, ok);
    @(negedge clk);
    checks++;
    if (!ok || {in_base.tready, in_exp.tready, in_mod.tready} !== 3'b110) begin
      errors++;
      $display("FAIL ordered_ready_drop got %b expected 110 accepted %0d",
               {in_base.tready, in_exp.tready, in_mod.tready}, ok);
    end
    @(negedge clk);
    send_one(1, 64'd5, ok);
    @(negedge clk);
    @(negedge clk);
    send_one(0, 64'd3, ok);
    @(negedge clk);
    collect(0, tx0, res, tx, st, to);
    checks++;
    if (to || res !== ref_pow(64'd3, 64'd5, 64'd7)) begin
      errors++;
      $display("FAIL ordered_result got %0d expected %0d timeout %0d", res,
               ref_pow(64'd3, 64'd5, 64'd7), to);
    end
    checks++;
    if (tx !== ref_tx(64'd5, 64'd7)) begin
      errors++;
      $display("FAIL ordered_tx got %0d expected %0d", tx, ref_tx(64'd5, 64'd7));
    end
  endtask

  task automatic test_special;
    logic [63:0] bs[3] = '{64'd10, 64'd5, 64'd99};
    logic [63:0] es[3] = '{64'd0, 64'd3, 64'd12};
    logic [63:0] ms[3] = '{64'd13, 64'd1, 64'd0};
    logic [63:0] res;
    int tx;
    bit st, to;
    for (int i = 0; i < 3; i++) begin
      run_exp(bs[i], es[i], ms[i], 0, res, tx, st, to);
      checks++;
      if (to || res !== ref_pow(bs[i], es[i], ms[i]) || tx !== 0) begin
        errors++;
        $display("FAIL special_%0d got %0d tx %0d expected %0d tx 0", i, res, tx,
                 ref_pow(bs[i], es[i], ms[i]));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] res;
    int tx;
    bit st, to;
    bp_en = 1'b1; max_delay = 20;
    run_exp(64'd2, 64'd10, 64'd1000, 10, res, tx, st, to);
    bp_en = 1'b0;
    checks++;
    if (to || res !== ref_pow(64'd2, 64'd10, 64'd1000)) begin
      errors++;
      $display("FAIL bp_result got %0d expected %0d timeout %0d", res,
               ref_pow(64'd2, 64'd10, 64'd1000), to);
    end
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL bp_hold_stable got unstable expected stable");
    end
    checks++;
    if (tx !== ref_tx(64'd10, 64'd1000)) begin
      errors++;
      $display("FAIL bp_tx got %0d expected %0d", tx, ref_tx(64'd10, 64'd1000));
    end
  endtask

  task automatic test_random;
    logic [63:0] b, e, m, res, mask;
    int tx, w;
    bit st, to;
    for (int n = 0; n < 9; n++) begin
      b = {$urandom, $urandom};
      if (n == 8) begin
        e = {$urandom, $urandom};
        bp_en = 1'b0;
      end else begin
        w = $urandom_range(1, 16);
        mask = (64'd1 << w) - 64'd1;
        e = {$urandom, $urandom} & mask;
        bp_en = $urandom_range(0, 1) == 1;
        max_delay = $urandom_range(0, 20);
      end
      case ($urandom_range(0, 3))
        0: m = {$urandom, $urandom};
        1: m = 64'($urandom_range(2, 1000));
        2: m = 64'($urandom_range(0, 1));
        default: m = {1'b1, 31'($urandom), $urandom};
      endcase
      run_exp(b, e, m, $urandom_range(0, 3), res, tx, st, to);
      checks++;
      if (to || res !== ref_pow(b, e, m) || tx !== ref_tx(e, m)) begin
        errors++;
        $display("FAIL random_%0d got %0d tx %0d expected %0d tx %0d (b=%0d e=%0d m=%0d)",
                 n, res, tx, ref_pow(b, e, m), ref_tx(e, m), b, e, m);
      end
    end
    bp_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [518:0] outs;
    logic [63:0] res;
    int tx, rises;
    bit ok, st, to, prev;
    send_all(64'd3, 64'd5, 64'd7, ok);
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 500 && rises < 2; i++) begin
      if (mul_r.tready === 1'b1 && !prev) rises++;
      prev = mul_r.tready;
      if (rises < 2) @(negedge clk);
    end
    checks++;
    if (!ok || rises < 2) begin
      errors++;
      $display("FAIL reset_mid_reach_sqr got %0d waits expected 2", rises);
    end
    rst = 1'b1;
    #1;
    outs = {in_base.tready, in_exp.tready, in_mod.tready, out_res.tvalid, out_res.tdata,
            mul_a.tvalid, mul_a.tdata, mul_b.tvalid, mul_b.tdata, mul_m.tvalid, mul_m.tdata,
            mul_r.tready, 64'd0};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_exp(64'd2, 64'd10, 64'd1000, 0, res, tx, st, to);
    checks++;
    if (to || res !== ref_pow(64'd2, 64'd10, 64'd1000) || tx !== ref_tx(64'd10, 64'd1000)) begin
      errors++;
      $display("FAIL after_reset_result got %0d tx %0d expected %0d tx %0d", res, tx,
               ref_pow(64'd2, 64'd10, 64'd1000), ref_tx(64'd10, 64'd1000));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_base.tvalid = 1'b0; in_base.tdata = 64'd0;
    in_exp.tvalid  = 1'b0; in_exp.tdata  = 64'd0;
    in_mod.tvalid  = 1'b0; in_mod.tdata  = 64'd0;
    out_res.tready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_bit();
    test_ordered();
    test_special();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_exp_controller.md
Name: mod_exp_controller

Overview:
- Computes result = base^exponent mod modulus using right-to-left square-and-multiply.
- Acts as the initiator of the multiplication_modulo stream interface: drives its multiplier, multiplicand and modulus input streams and consumes its output stream.
- Sits above multiplication_modulo as the exponentiation engine for the ElGamal datapath, for example for g^k mod p and y^k mod p.

Parameters:
SIZE, 64, width of every data word (base, exponent, modulus, result).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
input_base_tdata  input  SIZE  base operand.
input_base_tvalid  input  1  base valid.
input_base_tready  output  1  base accepted when tvalid and tready are both high.
input_exponent_tdata  input  SIZE  exponent.
input_exponent_tvalid  input  1  exponent valid.
input_exponent_tready  output  1  exponent ready.
input_modulus_tdata  input  SIZE  modulus.
input_modulus_tvalid  input  1  modulus valid.
input_modulus_tready  output  1  modulus ready.
output_tdata  output  SIZE  exponentiation result.
output_tvalid  output  1  result valid.
output_tready  input  1  downstream ready.
mul_multiplier_tdata  output  SIZE  to multiplication_modulo multiplier.
mul_multiplier_tvalid  output  1  multiplier valid.
mul_multiplier_tready  input  1  multiplier ready.
mul_multiplicand_tdata  output  SIZE  to multiplicand.
mul_multiplicand_tvalid  output  1  multiplicand valid.
mul_multiplicand_tready  input  1  multiplicand ready.
mul_modulus_tdata  output  SIZE  to modulus.
mul_modulus_tvalid  output  1  modulus valid.
mul_modulus_tready  input  1  modulus ready.
mul_result_tdata  input  SIZE  from multiplication_modulo output.
mul_result_tvalid  input  1  product valid.
mul_result_tready  output  1  product ready.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: all tvalid and tready outputs 0, all tdata outputs 0, state IDLE, internal registers 0.
- IDLE: each input_*_tready is high until its own operand is captured, then low. The three operands are captured independently and in any order. When all three are held, the block moves to CHECK on the next cycle.
- CHECK, special cases:
  - modulus 0 or 1: result 0, go to DONE.
  - exponent 0 with modulus greater than 1: result 1, go to DONE.
  - Otherwise: acc=1, b=base, e=exponent, go to STEP.
- STEP:
  - If e[0]=1, run MUL (acc := acc*b mod m).
  - Then e := e>>1.
  - Then run SQR (b := b*b mod m), except as noted under Optional Feature.
  - After SQR, return to STEP if e is nonzero; otherwise go to DONE.
- MUL and SQR transactions:
  - ISSUE: drive multiplier=acc (MUL) or b (SQR), multiplicand=b, modulus=m. Raise all three tvalid together. Each tvalid drops the cycle after its own handshake; each channel completes independently.
  - When all three channels have completed, go to WAIT.
  - WAIT: mul_result_tready=1. On a result handshake, write acc or b and continue.
  - mul_result_tready is 0 in every other state.
  - Ignore mul_result_tvalid outside WAIT.
- DONE:
  - output_tvalid=1 with output_tdata stable until output_tready is high.
  - After the handshake, return to IDLE (input readies high again) on the next cycle.
  - output_tready low holds the result indefinitely.
- Base is not pre-reduced; the first MUL or SQR reduces it.
- Transaction count: MUL count = popcount(exponent). SQR count = bit length of the exponent.
- rst asserted mid-operation: immediate return to reset values. Any pending product from the multiplier is dropped; the bench must reset both blocks together.

Optional Feature:
- Macro: MOD_EXP_SKIP_FINAL_SQUARE_EN.
- Defined: the SQR is skipped when e is zero after the shift, so SQR count = bit length - 1. The result is identical with the macro defined or undefined.
- Undefined: a SQR is issued after every processed bit.

Test Plan:
- base=143563561627, exp=1, mod=69814 -> output 6819.
  - 2 multiplier transactions (1 MUL, 1 SQR).
  - 1 transaction with MOD_EXP_SKIP_FINAL_SQUARE_EN.
- base=3, exp=5, mod=7, operands presented in order modulus, exponent, base on separate cycles -> output 5.
  - 5 transactions (2 MUL, 3 SQR).
  - 4 with MOD_EXP_SKIP_FINAL_SQUARE_EN.
- exp=0, base=10, mod=13 -> output 1, zero multiplier transactions. mod=1, base=5, exp=3 -> output 0, zero transactions.
- base=2, exp=10, mod=1000 with randomized backpressure on mul_*_tready, mul_result_tvalid delays of 0-20 cycles, and output_tready low for 10 cycles -> output 24, held stable while tready is low.
- Assert rst for one cycle during a SQR WAIT of a 3^5 mod 7 run -> all outputs return to reset values immediately. A following 2^10 mod 1000 run -> 24.
